// File: rtl/riscv_pkg.sv
// Shared encodings for the iterative divider: operation select and FSM states.
package riscv_pkg;

    // Operation select as presented on the OP port.
    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;

    // Divider sequencing states.
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } div_state_e;

    // DIV and REM treat the operands as two's-complement numbers.
    function automatic logic op_is_signed(div_op_e op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    // REM and REMU return the remainder, the others the quotient.
    function automatic logic op_is_rem(div_op_e op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/sub_cla.sv
// Carry-lookahead subtractor: diff = a - b computed as a + ~b + 1.
// Every carry is expanded directly from the bit generate/propagate terms,
// so no carry depends on another carry.
module sub_cla #(
    parameter int W = 33
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] diff_o,
    output logic         borrow_o
);

    logic [W-1:0] gen_bit;
    logic [W-1:0] prop_bit;
    logic [W:0]   carry;

    // Per-bit generate and propagate for a + ~b.
    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_gp
            assign gen_bit[gi]  = a_i[gi] & ~b_i[gi];
            assign prop_bit[gi] = a_i[gi] ^ ~b_i[gi];
        end
    endgenerate

    // Lookahead carries: carry[i] = G[i-1:0] | P[i-1:0] & cin, with cin = 1.
    always_comb begin
        logic gen_acc;
        logic prop_acc;
        carry    = '0;
        carry[0] = 1'b1;
        for (int i = 1; i <= W; i++) begin
            gen_acc  = 1'b0;
            prop_acc = 1'b1;
            for (int j = i - 1; j >= 0; j--) begin
                gen_acc  = gen_acc | (prop_acc & gen_bit[j]);
                prop_acc = prop_acc & prop_bit[j];
            end
            carry[i] = gen_acc | prop_acc;
        end
    end

    assign diff_o   = prop_bit ^ carry[W-1:0];
    // No carry out of the top bit means b was larger than a.
    assign borrow_o = ~carry[W];

endmodule

// File: rtl/div_unit.sv
// Iterative restoring divider supporting DIV, DIVU, REM and REMU.
// Magnitudes are divided one quotient bit per cycle, signs are applied in a
// single fixup cycle; divide-by-zero and signed overflow bypass the loop.
module div_unit
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            START,
    input  logic [1:0]      OP,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    output logic            BUSY,
    output logic            DONE,
    output logic [XLEN-1:0] RESULT
);

    localparam int              CNT_W    = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

    div_state_e      state_q,   state_d;
    div_op_e         op_q,      op_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [XLEN-1:0] rem_q,     rem_d;      // partial remainder
    logic [XLEN-1:0] quo_q,     quo_d;      // dividend shifting out, quotient shifting in
    logic [XLEN-1:0] dvsr_q,    dvsr_d;     // divisor magnitude
    logic            neg_quo_q, neg_quo_d;
    logic            neg_rem_q, neg_rem_d;
    logic [XLEN-1:0] result_q,  result_d;

    // Request decode on the START operands.
    div_op_e         start_op;
    logic            start_signed;
    logic            a_neg;
    logic            b_neg;
    logic            accept;
    logic            div_by_zero;
    logic            overflow;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic [XLEN-1:0] short_result;

    assign start_op     = div_op_e'(OP);
    assign start_signed = op_is_signed(start_op);
    assign a_neg        = start_signed & A[XLEN-1];
    assign b_neg        = start_signed & B[XLEN-1];
    assign accept       = START && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign div_by_zero  = (B == '0);
    assign overflow     = start_signed && (A == MIN_NEG) && (B == ALL_ONES);
    assign a_mag        = a_neg ? -A : A;
    assign b_mag        = b_neg ? -B : B;

    // Results for the cases that never enter the division loop.
    always_comb begin
        short_result = '0;
        if (div_by_zero) begin
            short_result = op_is_rem(start_op) ? A : ALL_ONES;
        end else begin
            short_result = op_is_rem(start_op) ? '0 : MIN_NEG;
        end
    end

    // Trial subtraction of the divisor from the shifted partial remainder.
    logic [XLEN:0]   trial;
    logic [XLEN:0]   trial_diff;
    logic            trial_borrow;
    logic            trial_msb_unused;

    assign trial = {rem_q, quo_q[XLEN-1]};

    sub_cla #(
        .W (XLEN + 1)
    ) u_sub_cla (
        .a_i      (trial),
        .b_i      ({1'b0, dvsr_q}),
        .diff_o   (trial_diff),
        .borrow_o (trial_borrow)
    );

    // The remainder stays below the divisor, so the top difference bit is
    // always zero whenever the difference is kept.
    assign trial_msb_unused = trial_diff[XLEN];

    // Signed fixup of the magnitude results.
    logic [XLEN-1:0] quo_fix;
    logic [XLEN-1:0] rem_fix;

    assign quo_fix = neg_quo_q ? -quo_q : quo_q;
    assign rem_fix = neg_rem_q ? -rem_q : rem_q;

    // Next-state and datapath control for the divider sequence.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvsr_d    = dvsr_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    op_d = start_op;
                    if (div_by_zero || overflow) begin
                        result_d = short_result;
                        cnt_d    = '0;
                        state_d  = S_DONE;
                    end else begin
                        quo_d     = a_mag;
                        dvsr_d    = b_mag;
                        rem_d     = '0;
                        neg_quo_d = a_neg ^ b_neg;
                        neg_rem_d = a_neg;
                        cnt_d     = CNT_LAST;
                        state_d   = S_CALC;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_CALC: begin
                if (trial_borrow) begin
                    rem_d = trial[XLEN-1:0];
                    quo_d = {quo_q[XLEN-2:0], 1'b0};
                end else begin
                    rem_d = trial_diff[XLEN-1:0];
                    quo_d = {quo_q[XLEN-2:0], 1'b1};
                end
                if (cnt_q == '0) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            S_FIX: begin
                result_d = op_is_rem(op_q) ? rem_fix : quo_fix;
                state_d  = S_DONE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            op_q      <= OP_DIV;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvsr_q    <= dvsr_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
        end
    end

    assign BUSY   = (state_q == S_CALC) || (state_q == S_FIX);
    assign DONE   = (state_q == S_DONE);
    assign RESULT = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: a transaction-level model predicts BUSY/DONE/RESULT on
// every cycle, directed vectors carry hand-computed results and latencies.
module tb_div_unit;

    localparam int XLEN = 32;
    localparam logic [1:0] OPC_DIV  = 2'b00;
    localparam logic [1:0] OPC_DIVU = 2'b01;
    localparam logic [1:0] OPC_REM  = 2'b10;
    localparam logic [1:0] OPC_REMU = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    div_unit #(
        .XLEN (XLEN)
    ) dut (
        .CLK    (clk),
        .RST    (rst),
        .START  (start),
        .OP     (op),
        .A      (a),
        .B      (b),
        .BUSY   (busy),
        .DONE   (done),
        .RESULT (result)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Architectural result of one operation, from plain arithmetic.
    function automatic logic [31:0] model_result(input logic [1:0] o, input logic [31:0] x,
                                                 input logic [31:0] y);
        int  sx;
        int  sy;
        bit  ovf;
        sx  = x;
        sy  = y;
        ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        case (o)
            OPC_DIVU: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            OPC_REMU: return (y == 0) ? x : x % y;
            OPC_DIV: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (ovf)    return 32'h8000_0000;
                return 32'(sx / sy);
            end
            default: begin
                if (y == 0) return x;
                if (ovf)    return 32'h0;
                return 32'(sx % sy);
            end
        endcase
    endfunction

    // Operations that complete in the cycle right after START.
    function automatic bit model_short(input logic [1:0] o, input logic [31:0] x,
                                       input logic [31:0] y);
        bit sgn;
        sgn = (o == OPC_DIV) || (o == OPC_REM);
        return (y == 0) || (sgn && (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF));
    endfunction

    // Cycle-level expectation: an accepted long op shows BUSY for 33 cycles
    // then DONE; a short op shows DONE in the next cycle.
    logic        m_busy   = 1'b0;
    logic        m_done   = 1'b0;
    logic [31:0] m_result = '0;
    logic [31:0] m_pend   = '0;
    int          m_left   = 0;
    bit          m_valid  = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_left   <= 0;
            m_busy   <= 1'b0;
            m_done   <= 1'b0;
            m_result <= '0;
            m_valid  <= 1'b1;
        end else begin
            m_done <= 1'b0;
            if (m_left > 1) begin
                m_left <= m_left - 1;
            end else if (m_left == 1) begin
                m_left   <= 0;
                m_busy   <= 1'b0;
                m_done   <= 1'b1;
                m_result <= m_pend;
            end else if (start) begin
                if (model_short(op, a, b)) begin
                    m_done   <= 1'b1;
                    m_result <= model_result(op, a, b);
                end else begin
                    m_left <= 33;
                    m_busy <= 1'b1;
                    m_pend <= model_result(op, a, b);
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            check("cyc busy",   32'(busy), 32'(m_busy));
            check("cyc done",   32'(done), 32'(m_done));
            check("cyc result", result,    m_result);
        end
    end

    // Pulse START for one cycle, then count cycles until DONE (bounded).
    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         output int lat, output int busy_cyc);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        lat      = 0;
        busy_cyc = 0;
        do begin
            @(negedge clk);
            lat++;
            if (busy) busy_cyc++;
        end while (!done && lat < 100);
    endtask

    task automatic run(input string name, input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] exp_res, input int exp_lat);
        int lat;
        int bc;
        check({name, " model"}, model_result(o, x, y), exp_res);
        issue(o, x, y, lat, bc);
        check({name, " latency"}, 32'(lat), 32'(exp_lat));
        check({name, " result"}, result, exp_res);
        check({name, " busy cycles"}, 32'(bc), (exp_lat == 34) ? 32'd33 : 32'd0);
        $display("%s op=%0d a=%h b=%h result=%h latency=%0d", name, o, x, y, result, lat);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  lat;
        int  bc;
        bit  seen;
        rst   = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        check("reset busy",   32'(busy), 32'd0);
        check("reset done",   32'(done), 32'd0);
        check("reset result", result,    32'd0);
        rst = 1'b0;
        idle(1);

        run("divu 100/7",   OPC_DIVU, 32'd100,        32'd7,          32'd14,         34); idle(2);
        run("remu 100/7",   OPC_REMU, 32'd100,        32'd7,          32'd2,          34); idle(2);
        run("div -7/2",     OPC_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  34); idle(2);
        run("rem -7/2",     OPC_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  34); idle(2);
        run("divu 5/0",     OPC_DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF,  1);  idle(2);
        run("remu 5/0",     OPC_REMU, 32'd5,          32'd0,          32'd5,          1);  idle(2);
        run("div ovf",      OPC_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1);  idle(2);
        run("rem ovf",      OPC_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1);  idle(2);
        run("div 5/0",      OPC_DIV,  32'd5,          32'd0,          32'hFFFF_FFFF,  1);  idle(2);
        run("rem -5/0",     OPC_REM,  32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  1);  idle(2);
        run("div 7/-2",     OPC_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  34); idle(2);
        run("rem 7/-2",     OPC_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          34); idle(2);
        run("div -100/-7",  OPC_DIV,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         34); idle(2);
        run("rem -100/-7",  OPC_REM,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  34); idle(2);
        run("divu min/max", OPC_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          34); idle(2);
        run("remu min/max", OPC_REMU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  34); idle(2);
        run("divu max/1",   OPC_DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  34); idle(2);
        run("div min/3",    OPC_DIV,  32'h8000_0000,  32'd3,          32'hD555_5556,  34); idle(2);
        run("rem min/3",    OPC_REM,  32'h8000_0000,  32'd3,          32'hFFFF_FFFE,  34); idle(2);

        // START with new operands mid-operation must not disturb it.
        op    = OPC_DIVU;
        a     = 32'd100;
        b     = 32'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 10) begin
                a     = 32'd9;
                b     = 32'd3;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end while (!done && lat < 100);
        start = 1'b0;
        check("ignore latency", 32'(lat), 32'd34);
        check("ignore result",  result,   32'd14);
        $display("ignore-start divu 100/7 result=%h latency=%0d", result, lat);
        idle(2);

        // Reset in the middle of CALC aborts the operation.
        op    = OPC_DIVU;
        a     = 32'd100;
        b     = 32'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 1; k <= 15; k++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst busy",   32'(busy), 32'd0);
        check("midrst done",   32'(done), 32'd0);
        check("midrst result", result,    32'd0);
        seen = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("midrst no done", 32'(seen), 32'd0);
        $display("mid-calc reset busy=%0d done=%0d result=%h", busy, done, result);

        // Reset wins over START in the same cycle.
        op    = OPC_DIVU;
        a     = 32'd100;
        b     = 32'd7;
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        check("rstprio busy", 32'(busy), 32'd0);
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        check("rstprio idle", 32'(seen), 32'd0);
        $display("reset-over-start busy=%0d done=%0d", busy, done);

        // Back-to-back: START held in the DONE cycle.
        issue(OPC_DIVU, 32'd50, 32'd5, lat, bc);
        check("b2b first latency", 32'(lat),  32'd34);
        check("b2b first result",  result,    32'd10);
        check("b2b done busy",     32'(busy), 32'd0);
        $display("b2b first divu 50/5 result=%h latency=%0d", result, lat);
        issue(OPC_DIVU, 32'd50, 32'd5, lat, bc);
        check("b2b second latency", 32'(lat), 32'd34);
        check("b2b second busy",    32'(bc),  32'd33);
        check("b2b second result",  result,   32'd10);
        $display("b2b second divu 50/5 result=%h latency=%0d", result, lat);
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
